median_pipe: RTL and testbench

Pipelined, parametrised median/order-statistics engine for the noise-detection datapath. Accepts one packed window of `WINDOW_S` pixels per cycle and produces min, median and max through a registered odd-even transposition sorting network. Adds a valid/ready handshake with full-pipeline stall and an optional impulse-noise decision on the centre pixel. It sits between the window buffer and the pixel writer, and supersedes the combinational 3x3/5x5 median.

---
 rtl/median_pipe.sv | 126 ++++++++++++
 tb/tb_median_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_pipe.sv
// Registered odd-even transposition sorter giving min/median/max (plus optional noise flag via MEDIAN_NOISE_DETECT_EN).
// Latency WINDOW_S edges, one window per cycle; out_valid && !out_ready freezes every stage and drops in_ready.
module median_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int WINDOW_S    = 25,
    parameter int WINDOW_BITS = 200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WINDOW_BITS-1:0] in_window,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  min_out,
    output logic [DATA_WIDTH-1:0]  med_out,
    output logic [DATA_WIDTH-1:0]  max_out,
    output logic [DATA_WIDTH-1:0]  center_out
`ifdef MEDIAN_NOISE_DETECT_EN
    ,
    output logic                   noise_out,
    output logic [DATA_WIDTH-1:0]  pix_out
`endif
);

    localparam int N = WINDOW_S;
    localparam int W = DATA_WIDTH;
    localparam int C = (WINDOW_S - 1) / 2;

    logic [W-1:0] stg_q [N][N];
    logic [W-1:0] stg_d [N][N];
    logic [W-1:0] ctr_q [N];
    logic [W-1:0] ctr_d [N];
    logic [N-1:0] vld_q;
    logic [N-1:0] vld_d;
    logic         stall;

    assign out_valid = vld_q[N-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign vld_d     = {vld_q[N-2:0], in_valid};

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [W-1:0] src [N];

        for (genvar i = 0; i < N; i++) begin : g_src
            if (k == 0) begin : g_first
                assign src[i] = in_window[i*W +: W];
            end else begin : g_next
                assign src[i] = stg_q[k-1][i];
            end
        end

        // Even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4)..
        for (genvar i = 0; i < N; i++) begin : g_ce
            if (((i % 2) == (k % 2)) && (i + 1 < N)) begin : g_lo
                assign stg_d[k][i] = (src[i] > src[i+1]) ? src[i+1] : src[i];
            end else if ((i >= 1) && (((i - 1) % 2) == (k % 2))) begin : g_hi
                assign stg_d[k][i] = (src[i-1] > src[i]) ? src[i-1] : src[i];
            end else begin : g_pass
                assign stg_d[k][i] = src[i];
            end
        end

        if (k == 0) begin : g_ctr_first
            assign ctr_d[k] = in_window[C*W +: W];
        end else begin : g_ctr_next
            assign ctr_d[k] = ctr_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                ctr_q[k] <= '0;
                for (int i = 0; i < N; i++) begin
                    stg_q[k][i] <= '0;
                end
            end
        end else if (!stall) begin
            stg_q <= stg_d;
            ctr_q <= ctr_d;
        end
    end

    assign min_out    = stg_q[N-1][0];
    assign med_out    = stg_q[N-1][C];
    assign max_out    = stg_q[N-1][N-1];
    assign center_out = ctr_q[N-1];

`ifdef MEDIAN_NOISE_DETECT_EN
    logic         noise_d;
    logic         noise_q;
    logic [W-1:0] pix_d;
    logic [W-1:0] pix_q;

    // Decided from the final stage's inputs so the flag lands with the sorted result.
    assign noise_d = (ctr_d[N-1] == stg_d[N-1][0]) || (ctr_d[N-1] == stg_d[N-1][N-1]);
    assign pix_d   = noise_d ? stg_d[N-1][C] : ctr_d[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noise_q <= 1'b0;
            pix_q   <= '0;
        end else if (!stall) begin
            noise_q <= noise_d;
            pix_q   <= pix_d;
        end
    end

    assign noise_out = noise_q;
    assign pix_out   = pix_q;
`endif

endmodule

// File: tb/tb_median_pipe.sv
// Directed and randomized bench for median_pipe (N=25 main instance, N=9 secondary instance).
module tb_median_pipe;

    localparam int N  = 25;
    localparam int W  = 8;
    localparam int NB = N * W;
    localparam int N9 = 9;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_window;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  min_out, med_out, max_out, center_out;

    logic           in9_valid;
    logic           in9_ready;
    logic [N9*W-1:0] in9_window;
    logic           out9_valid;
    logic [W-1:0]   min9, med9, max9, ctr9;

`ifdef MEDIAN_NOISE_DETECT_EN
    logic         noise_out, noise9;
    logic [W-1:0] pix_out, pix9;
`endif

    int checks = 0;
    int errors = 0;

    median_pipe #(.DATA_WIDTH(W), .WINDOW_S(N), .WINDOW_BITS(NB)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
        .out_valid(out_valid), .out_ready(out_ready),
        .min_out(min_out), .med_out(med_out), .max_out(max_out), .center_out(center_out)
`ifdef MEDIAN_NOISE_DETECT_EN
        , .noise_out(noise_out), .pix_out(pix_out)
`endif
    );

    median_pipe #(.DATA_WIDTH(W), .WINDOW_S(N9), .WINDOW_BITS(N9*W)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in9_valid), .in_ready(in9_ready), .in_window(in9_window),
        .out_valid(out9_valid), .out_ready(1'b1),
        .min_out(min9), .med_out(med9), .max_out(max9), .center_out(ctr9)
`ifdef MEDIAN_NOISE_DETECT_EN
        , .noise_out(noise9), .pix_out(pix9)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: sort the window as a list of numbers and pick ranks.
    function automatic void ref_stats(input logic [NB-1:0] w, output int mn, output int md,
                                      output int mx, output int ct);
        int q[$];
        for (int i = 0; i < N; i++) q.push_back(int'(w[i*W +: W]));
        ct = q[(N-1)/2];
        q.sort();
        mn = q[0];
        md = q[(N-1)/2];
        mx = q[N-1];
    endfunction

    function automatic logic [NB-1:0] rand_win(input int unsigned maxv);
        logic [NB-1:0] w;
        for (int i = 0; i < N; i++) w[i*W +: W] = W'($urandom_range(maxv, 0));
        return w;
    endfunction

    task automatic chk_res(input string tag, input int mn, input int md, input int mx, input int ct);
`ifdef MEDIAN_NOISE_DETECT_EN
        int en;
`endif
        chk({tag, "_min"}, 32'(min_out), mn);
        chk({tag, "_med"}, 32'(med_out), md);
        chk({tag, "_max"}, 32'(max_out), mx);
        chk({tag, "_center"}, 32'(center_out), ct);
`ifdef MEDIAN_NOISE_DETECT_EN
        en = ((ct == mn) || (ct == mx)) ? 1 : 0;
        chk({tag, "_noise"}, 32'(noise_out), en);
        chk({tag, "_pix"}, 32'(pix_out), (en != 0) ? md : ct);
`endif
    endtask

    task automatic run_one(input logic [NB-1:0] w, input string tag,
                           input int mn, input int md, input int mx, input int ct);
        int lat;
        in_window = w;
        in_valid  = 1'b1;
        cycle();
        in_valid  = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            cycle();
            lat++;
        end
        chk({tag, "_latency"}, lat, 25);
        chk_res(tag, mn, md, mx, ct);
        cycle();
        chk({tag, "_drain"}, 32'(out_valid), 0);
    endtask

    initial begin
        logic [NB-1:0] w;
        logic [NB-1:0] wins [30];
        logic [NB-1:0] expq [$];
        int mn, md, mx, ct;
        int sent, rcv, seen, lat;
        logic stalled_prev;
        logic [W-1:0] s_min, s_med, s_max, s_ctr;

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_window = '0;
        in9_valid = 1'b0; in9_window = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_min", 32'(min_out), 0);
        chk("rst_med", 32'(med_out), 0);
        chk("rst_max", 32'(max_out), 0);
        chk("rst_center", 32'(center_out), 0);
`ifdef MEDIAN_NOISE_DETECT_EN
        chk("rst_noise", 32'(noise_out), 0);
        chk("rst_pix", 32'(pix_out), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < N; i++) w[i*W +: W] = W'(i);
        run_one(w, "asc", 0, 12, 24, 12);
        for (int i = 0; i < N; i++) w[i*W +: W] = W'(200 - i);
        run_one(w, "desc", 176, 188, 200, 188);
        for (int i = 0; i < N; i++) w[i*W +: W] = W'(7);
        run_one(w, "const", 7, 7, 7, 7);
        // 22 is displaced by 255, so rank 12 of the sorted window is 23.
        for (int i = 0; i < N; i++) w[i*W +: W] = W'(10 + i);
        w[12*W +: W] = 8'd255;
        run_one(w, "impulse", 10, 23, 255, 255);

        for (int i = 0; i < 30; i++) wins[i] = rand_win((i % 2 == 0) ? 255 : 15);
        sent = 0; rcv = 0; stalled_prev = 1'b0;
        s_min = '0; s_med = '0; s_max = '0; s_ctr = '0;
        for (int c = 0; c < 300 && rcv < 30; c++) begin
            in_valid  = (sent < 30);
            in_window = (sent < 30) ? wins[sent] : '0;
            out_ready = !(c >= 26 && c <= 29);
            #1;
            chk("b2b_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (stalled_prev) begin
                chk("b2b_hold_valid", 32'(out_valid), 1);
                chk("b2b_hold_min", 32'(min_out), 32'(s_min));
                chk("b2b_hold_med", 32'(med_out), 32'(s_med));
                chk("b2b_hold_max", 32'(max_out), 32'(s_max));
                chk("b2b_hold_center", 32'(center_out), 32'(s_ctr));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("b2b_unexpected_out", 32'(out_valid), 0);
                end else begin
                    ref_stats(expq.pop_front(), mn, md, mx, ct);
                    chk_res("b2b", mn, md, mx, ct);
                end
                rcv++;
            end
            stalled_prev = out_valid && !out_ready;
            s_min = min_out; s_med = med_out; s_max = max_out; s_ctr = center_out;
            if (in_valid && in_ready) begin
                expq.push_back(wins[sent]);
                sent++;
            end
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("b2b_received", rcv, 30);
        chk("b2b_sent", sent, 30);
        seen = 0;
        repeat (30) begin cycle(); if (out_valid) seen++; end
        chk("b2b_no_extra", seen, 0);

        for (int i = 0; i < 5; i++) begin
            in_window = rand_win(255); in_valid = 1'b1; cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_min", 32'(min_out), 0);
        chk("arst_med", 32'(med_out), 0);
        chk("arst_max", 32'(max_out), 0);
        chk("arst_center", 32'(center_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin cycle(); if (out_valid) seen++; end
        chk("arst_no_result", seen, 0);

        for (int i = 0; i < 5; i++) begin
            in_window = rand_win(255); in_valid = 1'b1; cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();
        flush = 1'b1; in_valid = 1'b1; in_window = rand_win(255);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 0);
        for (int i = 0; i < N; i++) w[i*W +: W] = W'(10 + i);
        w[12*W +: W] = 8'd255;
        run_one(w, "post_flush", 10, 23, 255, 255);
        seen = 0;
        repeat (40) begin cycle(); if (out_valid) seen++; end
        chk("flush_no_result", seen, 0);

        in9_window = {8'd6, 8'd4, 8'd8, 8'd2, 8'd7, 8'd1, 8'd9, 8'd3, 8'd5};
        in9_valid  = 1'b1;
        cycle();
        in9_valid  = 1'b0;
        lat = 1;
        while (out9_valid !== 1'b1 && lat < 40) begin cycle(); lat++; end
        chk("n9_latency", lat, 9);
        chk("n9_min", 32'(min9), 1);
        chk("n9_med", 32'(med9), 5);
        chk("n9_max", 32'(max9), 9);
        chk("n9_center", 32'(ctr9), 7);
`ifdef MEDIAN_NOISE_DETECT_EN
        chk("n9_noise", 32'(noise9), 0);
        chk("n9_pix", 32'(pix9), 7);
`endif
        chk("n9_in_ready", 32'(in9_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
